// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the integer register-file writeback path.
// Package riscv_wb_pkg: data/index widths, buffered result entry, ceil-log2 helper.
package riscv_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Writeback bus between the execute units, decode and the register-file write port.
// WB_FORWARD_EN adds the decode forwarding outputs rs1_fwd_hit, rs2_fwd_hit and fwd_data.
interface reg_writeback_if;
    import riscv_wb_pkg::*;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [REG_AW-1:0] mc_rd;
    logic [XLEN-1:0]   mc_data;
    logic              iss_valid;
    logic              iss_mc;
    logic [REG_AW-1:0] iss_rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd_data;
    logic              reg_write;

`ifdef WB_FORWARD_EN
    logic              rs1_fwd_hit;
    logic              rs2_fwd_hit;
    logic [XLEN-1:0]   fwd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_mc, iss_rd, rs1, rs2,
        output mc_ready, rs1_busy, rs2_busy, rd, rd_data, reg_write,
               rs1_fwd_hit, rs2_fwd_hit, fwd_data
    );
    modport master (
        output alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_mc, iss_rd, rs1, rs2,
        input  mc_ready, rs1_busy, rs2_busy, rd, rd_data, reg_write,
               rs1_fwd_hit, rs2_fwd_hit, fwd_data
    );
`else
    modport slave (
        input  alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_mc, iss_rd, rs1, rs2,
        output mc_ready, rs1_busy, rs2_busy, rd, rd_data, reg_write
    );
    modport master (
        output alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_mc, iss_rd, rs1, rs2,
        input  mc_ready, rs1_busy, rs2_busy, rd, rd_data, reg_write
    );
`endif

endinterface

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: synchronous FIFO of pending multi-cycle results; pushes while full and
// pops while empty are ignored so the caller may drive raw requests.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  wb_entry_t                   din_i,
    input  logic                        pop_i,
    output wb_entry_t                   dout_o,
    output logic                        empty_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            full_s;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign push_ok_s = push_i && !full_s;
    assign pop_ok_s  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and buffered multi-cycle results onto the single register-file
// write port and tracks pending multi-cycle destinations. Optional macro: WB_FORWARD_EN.
module reg_writeback
    import riscv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_writeback_if.slave   wb
);

    localparam int CW    = clog2(FIFO_DEPTH + 1);
    localparam int NREGS = 2 ** REG_AW;

    wb_entry_t          push_entry_s;
    wb_entry_t          head_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic               mc_ready_s;
    logic               push_s;
    logic               alu_wr_s;
    logic               pop_s;
    logic               fifo_wr_s;

    logic               reg_write_q, reg_write_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]    rd_data_q, rd_data_d;
    logic [NREGS-1:0]   busy_q, busy_d;
    logic [NREGS-1:0]   set_s, clr_s;

    assign mc_ready_s        = (fifo_count_s != CW'(FIFO_DEPTH));
    assign push_s            = wb.mc_valid && mc_ready_s;
    assign push_entry_s.rd   = wb.mc_rd;
    assign push_entry_s.data = wb.mc_data;

    // An ALU result aimed at x0 is a bubble, so the FIFO may drain under it.
    assign alu_wr_s  = wb.alu_valid && (wb.alu_rd != REG_AW'(0));
    assign pop_s     = !alu_wr_s && !fifo_empty_s;
    assign fifo_wr_s = pop_s && (head_s.rd != REG_AW'(0));

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .din_i   (push_entry_s),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Write-port source selection; index and data hold when nothing is written.
    always_comb begin
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        rd_data_d   = rd_data_q;
        if (alu_wr_s) begin
            reg_write_d = 1'b1;
            rd_d        = wb.alu_rd;
            rd_data_d   = wb.alu_data;
        end else if (fifo_wr_s) begin
            reg_write_d = 1'b1;
            rd_d        = head_s.rd;
            rd_data_d   = head_s.data;
        end else begin
            reg_write_d = 1'b0;
        end
    end

`ifdef WB_FORWARD_EN
    // Busy clears as the pop is registered; decode picks the value off the forward path.
    always_comb begin
        clr_s = {NREGS{1'b0}};
        if (fifo_wr_s) clr_s[head_s.rd] = 1'b1;
        else           clr_s = {NREGS{1'b0}};
    end

    assign wb.rs1_fwd_hit = reg_write_q && (rd_q == wb.rs1) && (wb.rs1 != REG_AW'(0));
    assign wb.rs2_fwd_hit = reg_write_q && (rd_q == wb.rs2) && (wb.rs2 != REG_AW'(0));
    assign wb.fwd_data    = rd_data_q;
`else
    logic from_fifo_q;

    // Busy clears only once the file has committed, so the stall spans the write cycle.
    always_comb begin
        clr_s = {NREGS{1'b0}};
        if (reg_write_q && from_fifo_q) clr_s[rd_q] = 1'b1;
        else                            clr_s = {NREGS{1'b0}};
    end

    // Remembers that the current write came from the FIFO.
    always_ff @(posedge clk) begin
        if (rst) from_fifo_q <= 1'b0;
        else     from_fifo_q <= !alu_wr_s && fifo_wr_s;
    end
`endif

    // Busy update: a same-edge set overrides the clear; x0 is never busy.
    always_comb begin
        set_s = {NREGS{1'b0}};
        if (wb.iss_valid && wb.iss_mc && (wb.iss_rd != REG_AW'(0))) set_s[wb.iss_rd] = 1'b1;
        else                                                        set_s = {NREGS{1'b0}};
        busy_d    = (busy_q & ~clr_s) | set_s;
        busy_d[0] = 1'b0;
    end

    // Output and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_q        <= REG_AW'(0);
            rd_data_q   <= XLEN'(0);
            busy_q      <= {NREGS{1'b0}};
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
        end
    end

    assign wb.mc_ready  = mc_ready_s;
    assign wb.rs1_busy  = (wb.rs1 != REG_AW'(0)) && busy_q[wb.rs1];
    assign wb.rs2_busy  = (wb.rs2 != REG_AW'(0)) && busy_q[wb.rs2];
    assign wb.rd        = rd_q;
    assign wb.rd_data   = rd_data_q;
    assign wb.reg_write = reg_write_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes are queued as stimulus is driven and
// matched against the write port at every falling edge.
module tb_reg_writeback;
    import riscv_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    wb_entry_t exp_q [$];
    wb_entry_t mon_e;

    always #5 clk = ~clk;

    reg_writeback_if ifc ();

    reg_writeback #(.FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.alu_valid = 1'b0; ifc.alu_rd = 5'd0; ifc.alu_data = 32'h0;
        ifc.mc_valid  = 1'b0; ifc.mc_rd  = 5'd0; ifc.mc_data  = 32'h0;
        ifc.iss_valid = 1'b0; ifc.iss_mc = 1'b0; ifc.iss_rd   = 5'd0;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wb_entry_t e;
        e.rd = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        ifc.alu_valid = 1'b1; ifc.alu_rd = r; ifc.alu_data = d;
        if (r != 5'd0) expect_wr(r, d);
    endtask

    task automatic mc(input logic [4:0] r, input logic [31:0] d);
        ifc.mc_valid = 1'b1; ifc.mc_rd = r; ifc.mc_data = d;
    endtask

    task automatic issue(input logic [4:0] r);
        ifc.iss_valid = 1'b1; ifc.iss_mc = 1'b1; ifc.iss_rd = r;
    endtask

    // Scoreboard: every write on the port must match the oldest expected write.
    always @(negedge clk) begin
        if (ifc.reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(ifc.reg_write), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_rd", 32'(ifc.rd), 32'(mon_e.rd));
                chk("wr_data", ifc.rd_data, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        ifc.rs1 = 5'd0;
        ifc.rs2 = 5'd0;
        step();
        step();
        chk("rst_we", 32'(ifc.reg_write), 32'h0);
        chk("rst_rd", 32'(ifc.rd), 32'h0);
        chk("rst_data", ifc.rd_data, 32'h0);
        chk("rst_ready", 32'(ifc.mc_ready), 32'h1);
        rst = 1'b0;

        // 1: ALU only, then x0 destination dropped with hold
        idle(); alu(5'd5, 32'h1234); step();
        chk("t1_we", 32'(ifc.reg_write), 32'h1);
        idle(); alu(5'd0, 32'hDEAD); step();
        chk("t1_x0_we", 32'(ifc.reg_write), 32'h0);
        chk("t1_hold_rd", 32'(ifc.rd), 32'h5);
        chk("t1_hold_data", ifc.rd_data, 32'h1234);
        idle(); step();

        // 2: ALU every cycle with one mc result parked behind
        for (int i = 0; i < 6; i++) begin
            idle();
            alu(5'(i + 1), 32'h100 + 32'(i));
            if (i == 0) mc(5'd7, 32'hAA);
            step();
        end
        idle(); expect_wr(5'd7, 32'hAA); step();
        chk("t2_pop_we", 32'(ifc.reg_write), 32'h1);
        idle(); step();

        // 3: fill the FIFO under ALU traffic
        idle(); alu(5'd10, 32'd10); mc(5'd20, 32'h2020); step();
        idle(); alu(5'd11, 32'd11); mc(5'd21, 32'h2121); step();
        idle(); alu(5'd12, 32'd12); mc(5'd22, 32'h2222); step();
        idle(); alu(5'd13, 32'd13); mc(5'd23, 32'h2323); step();
        chk("t3_full", 32'(ifc.mc_ready), 32'h0);
        idle(); alu(5'd14, 32'd14); mc(5'd24, 32'h2424); step();
        chk("t3_still_full", 32'(ifc.mc_ready), 32'h0);
        idle(); mc(5'd24, 32'h2424); expect_wr(5'd20, 32'h2020); step();
        chk("t3_ready_after_pop", 32'(ifc.mc_ready), 32'h1);
        idle(); mc(5'd24, 32'h2424); expect_wr(5'd21, 32'h2121); step();
        idle(); expect_wr(5'd22, 32'h2222); step();
        idle(); expect_wr(5'd23, 32'h2323); step();
        idle(); expect_wr(5'd24, 32'h2424); step();
        idle(); step();
        chk("t3_drained_ready", 32'(ifc.mc_ready), 32'h1);

        // 4: scoreboard set, clear timing, set-wins on same edge
        ifc.rs1 = 5'd9;
        idle(); issue(5'd9); step();
        chk("t4_busy_set", 32'(ifc.rs1_busy), 32'h1);
        chk("t4_rs2_x0", 32'(ifc.rs2_busy), 32'h0);
        idle(); mc(5'd9, 32'h99); step();
        chk("t4_busy_pending", 32'(ifc.rs1_busy), 32'h1);
        idle(); expect_wr(5'd9, 32'h99); step();
`ifdef WB_FORWARD_EN
        chk("t4_busy_write_cycle", 32'(ifc.rs1_busy), 32'h0);
`else
        chk("t4_busy_write_cycle", 32'(ifc.rs1_busy), 32'h1);
`endif
        idle(); step();
        chk("t4_busy_cleared", 32'(ifc.rs1_busy), 32'h0);
        idle(); issue(5'd9); step();
        idle(); mc(5'd9, 32'h77); step();
        idle(); expect_wr(5'd9, 32'h77);
`ifdef WB_FORWARD_EN
        issue(5'd9);
`endif
        step();
`ifndef WB_FORWARD_EN
        idle(); issue(5'd9); step();
`endif
        chk("t4_set_wins", 32'(ifc.rs1_busy), 32'h1);
        idle(); step();
        chk("t4_set_wins_hold", 32'(ifc.rs1_busy), 32'h1);

        // 5: reset with work in flight
        idle(); alu(5'd1, 32'h11); mc(5'd3, 32'h33); issue(5'd3); step();
        idle(); alu(5'd2, 32'h22); mc(5'd4, 32'h44); issue(5'd4); step();
        idle(); alu(5'd6, 32'h66); mc(5'd5, 32'h55); step();
        idle(); rst = 1'b1; step();
        rst = 1'b0;
        ifc.rs1 = 5'd3;
        ifc.rs2 = 5'd4;
        chk("t5_we", 32'(ifc.reg_write), 32'h0);
        chk("t5_ready", 32'(ifc.mc_ready), 32'h1);
        chk("t5_rs1_busy", 32'(ifc.rs1_busy), 32'h0);
        chk("t5_rs2_busy", 32'(ifc.rs2_busy), 32'h0);
        chk("t5_rd", 32'(ifc.rd), 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("t5_no_stale", 32'(ifc.reg_write), 32'h0);

        // 6: pop of rd=12 while decode reads it on rs2
        ifc.rs1 = 5'd0;
        ifc.rs2 = 5'd0;
        idle(); issue(5'd12); step();
        idle(); mc(5'd12, 32'hBEEF); step();
        idle(); expect_wr(5'd12, 32'hBEEF); ifc.rs2 = 5'd12; step();
        chk("t6_we", 32'(ifc.reg_write), 32'h1);
`ifdef WB_FORWARD_EN
        chk("t6_fwd_hit2", 32'(ifc.rs2_fwd_hit), 32'h1);
        chk("t6_fwd_hit1_x0", 32'(ifc.rs1_fwd_hit), 32'h0);
        chk("t6_fwd_data", ifc.fwd_data, 32'hBEEF);
        chk("t6_rs2_busy", 32'(ifc.rs2_busy), 32'h0);
`else
        chk("t6_rs2_busy", 32'(ifc.rs2_busy), 32'h1);
`endif
        idle(); step();
        chk("t6_rs2_clear", 32'(ifc.rs2_busy), 32'h0);
        step();

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
